// File: rtl/dp_ram_pkg.sv
// Shared constants and types for the parametrised dual-port RAM.
// RDW_MODE selects what a port returns when its address is written in the same cycle.
package dp_ram_pkg;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/dp_ram_init_seq.sv
// Post-reset zero-fill sequencer: walks the clear pointer across the array, then enters RUN.
// ready is decoded straight from the state register, so it is glitch-free.
module dp_ram_init_seq
  import dp_ram_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              init_we_o,
  output logic [ADDR_W-1:0] init_addr_o,
  output logic              ready_o,
  output state_t            state_o
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // The last clear write is the one at the all-ones pointer.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == INIT) begin
      ptr_d = ptr_q + 1'b1;
      if (&ptr_q) state_d = RUN;
    end
  end

  always_comb begin
    init_we_o   = (state_q == INIT);
    init_addr_o = ptr_q;
    ready_o     = (state_q == RUN);
    state_o     = state_q;
  end

endmodule

// File: rtl/dp_ram_param.sv
// True dual-port synchronous RAM with zero-fill after reset, deterministic
// same-address collision handling (port 1 wins) and selectable read-during-write.
module dp_ram_param
  import dp_ram_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int RDW_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en1,
  input  logic              en2,
  input  logic              we1,
  input  logic              we2,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] din1,
  input  logic [DATA_W-1:0] din2,
  output logic [DATA_W-1:0] dout1,
  output logic [DATA_W-1:0] dout2,
  output logic              valid1,
  output logic              valid2,
  output logic              ready,
  output logic              collision,
  output logic              dbg_state
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] dout1_q, dout1_d, dout2_q, dout2_d;
  logic              valid1_q, valid2_q, coll_q;
  logic              init_we;
  logic [ADDR_W-1:0] init_addr;
  state_t            state;
  logic              acc1, acc2, wr1, wr2, same_addr, coll_d;

  dp_ram_init_seq #(.ADDR_W(ADDR_W)) u_init_seq (
    .clk         (clk),
    .rst_n       (rst),
    .init_we_o   (init_we),
    .init_addr_o (init_addr),
    .ready_o     (ready),
    .state_o     (state)
  );

  always_comb begin
    acc1      = ready & en1;
    acc2      = ready & en2;
    wr1       = acc1 & we1;
    wr2       = acc2 & we2;
    same_addr = (addr1 == addr2);
    coll_d    = wr1 & wr2 & same_addr;
  end

  // Port 2's write is dropped on a collision so port 1 always owns the cell.
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem_q[init_addr] <= '0;
    end else begin
      if (wr2 && !coll_d) mem_q[addr2] <= din2;
      if (wr1)            mem_q[addr1] <= din1;
    end
  end

  // Write-first bypass returns whichever write actually lands in the cell.
  always_comb begin
    dout1_d = mem_q[addr1];
    dout2_d = mem_q[addr2];
    if (RDW_MODE == RDW_NEW) begin
      if (wr1)                   dout1_d = din1;
      else if (wr2 && same_addr) dout1_d = din2;
      if (wr1 && same_addr)      dout2_d = din1;
      else if (wr2)              dout2_d = din2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout1_q  <= '0;
      dout2_q  <= '0;
      valid1_q <= 1'b0;
      valid2_q <= 1'b0;
      coll_q   <= 1'b0;
    end else begin
      if (acc1) dout1_q <= dout1_d;
      if (acc2) dout2_q <= dout2_d;
      valid1_q <= acc1;
      valid2_q <= acc2;
      coll_q   <= coll_d;
    end
  end

  always_comb begin
    dout1     = dout1_q;
    dout2     = dout2_q;
    valid1    = valid1_q;
    valid2    = valid2_q;
    collision = coll_q;
    dbg_state = (state == RUN);
  end

endmodule

// File: doc/dp_ram_param.md
# dp_ram_param

Parametrised true dual-port synchronous RAM that replaces the fixed 8x256 two-port RAM. Width, depth and read-during-write mode are parameters. After reset, a built-in sequencer zero-fills the array and then raises `ready`. Same-address collisions are resolved deterministically and flagged, so callers in the datapath get defined results for every access combination.

## Interface
- `DATA_W`, 8, data width in bits (1..64).
- `ADDR_W`, 8, address width; DEPTH = 2**ADDR_W.
- `RDW_MODE`, 0, read-during-write result: 0 = old data (read-first), 1 = new data (write-first).

- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `en1`, `en2`  in  1  port access enable.
- `we1`, `we2`  in  1  write enable; qualified by `en`.
- `addr1`, `addr2`  in  ADDR_W  port address.
- `din1`, `din2`  in  DATA_W  write data.
- `dout1`, `dout2`  out  DATA_W  registered read data.
- `valid1`, `valid2`  out  1  `dout` updated this cycle.
- `ready`  out  1  init complete; accesses are accepted.
- `collision`  out  1  one-cycle pulse: both ports wrote the same address.

## Operation
- FSM states: INIT, RUN.
- **Reset (`rst`=0):** FSM goes to INIT and clear pointer to 0. All outputs are 0: `dout*`=0, `valid*`=0, `ready`=0, `collision`=0.
- **INIT:**
  - Each cycle writes 0 to mem[ptr], then ptr++.
  - After writing mem[DEPTH-1], the FSM moves to RUN.
  - `en*`/`we*` are ignored in INIT; `valid*` stays 0.
- **RUN:** port p accepts an access when `en_p`=1.
  - Read (`we_p`=0): `dout_p` <= mem[addr_p].
  - Write (`we_p`=1): mem[addr_p] <= din_p; `dout_p` <= old mem[addr_p] if RDW_MODE=0, else `din_p`.
  - `valid_p` <= `en_p`. When `en_p`=0, `dout_p` holds its value.
- **Both ports write the same address:**
  - Port 1 wins: mem <= din1.
  - `collision` <= 1 for exactly one cycle.
  - With RDW_MODE=1, both `dout1` and `dout2` return din1.
- **One port writes, the other reads the same address:**
  - Reader gets old data if RDW_MODE=0.
  - Reader gets the winning write data if RDW_MODE=1.
- **Different addresses:** the ports are fully independent. Address wrap-around is native modulo DEPTH.
- **Reset mid-RUN:** memory restarts the zero-fill. Prior contents are discarded.
- **Reset mid-INIT:** pointer returns to 0 and the fill restarts.

## Timing
- Read latency: 1 cycle. Address in cycle N gives `dout`/`valid` after edge N+1.
- `ready` rises at the edge that completes the write of mem[DEPTH-1], i.e. DEPTH cycles after `rst` deasserts. The first accepted access is on the following edge.
- `collision` is asserted in the cycle after the colliding edge and deasserts one cycle later unless the collision repeats.
- Writes are visible to any read issued on the next edge; no extra hazard cycles.
- Throughput: one access per port per cycle, sustained.

## Structure
- Package `dp_ram_pkg`:
  - constants RDW_OLD=0 and RDW_NEW=1;
  - FSM state type {INIT, RUN}.
- Sub-module `dp_ram_init_seq`: INIT/RUN FSM, clear pointer, `ready`. Outputs `init_we` and `init_addr` to the array write mux.
- Top level holds:
  - memory array;
  - per-port read registers;
  - collision compare/priority logic;
  - RDW bypass mux.

## Test plan
All scenarios use DATA_W=8, ADDR_W=4 (DEPTH=16).
- **Reset/init:** release `rst` at t0 with en1=en2=1 held.
  - `ready`=0 for 16 cycles, then 1.
  - `valid*` stays 0 until `ready`.
  - A read of addr 5 after `ready` returns 0x00.
- **Independent ports:**
  - Port 1 writes 0xCC to 2 while port 2 writes 0xAA to 9.
  - Next cycle, read both: dout1=0xCC, dout2=0xAA, `collision`=0.
- **Write-write collision:**
  - Both ports write addr 10: din1=0xCC, din2=0xAA.
  - `collision` pulses for 1 cycle; a later read of 10 returns 0xCC on both ports.
- **Cross-port read-during-write:**
  - mem[4]=0x11; port 1 writes 0xFF to 4 while port 2 reads 4.
  - RDW_MODE=0: dout2=0x11. RDW_MODE=1: dout2=0xFF.
- **Hold:**
  - en1=0 after reading 0xCC: dout1 stays 0xCC and valid1=0.
- **Reset mid-RUN:**
  - Write 0x5A to addr 15, then pulse `rst` low for 1 cycle.
  - `ready` drops and the 16-cycle init repeats; a read of 15 returns 0x00.
